uart_protocol_core: RTL and testbench
=====================================

Name: uart_protocol_core

Overview:
- Full-duplex 8N1 UART endpoint.
- Has a bus-side TX FIFO and RX FIFO, a 16x-oversampling baud generator, a serial transmitter and a serial receiver.
- Sits between a simple register/bus master and the serial pins. Two instances can be wired back-to-back, TX pin to RX pin.

Parameters:
- DATA_SIZE, 8, data bits per frame.
- SIZE_FIFO, 8, entries per FIFO; power of two.
- SYS_FREQ, 100000000, clk frequency in Hz.
- BAUD_RATE, 9600, serial bit rate.
- SAMPLE, 16, oversampling ticks per bit.
- BAUD_DVSR is derived, not overridable: SYS_FREQ/(SAMPLE*BAUD_RATE), integer division, 651 by default.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- write_data  in  1  push bus_data_in into TX FIFO this cycle.
- read_data  in  1  pop RX FIFO head this cycle.
- bus_data_in  in  DATA_SIZE  byte to transmit.
- bus_data_out  out  DATA_SIZE  RX FIFO head (first-word-fall-through).
- serial_data_in  in  1  asynchronous serial RX line.
- serial_data_out  out  1  serial TX line; idle high.
- TX_status_register  out  8  {5'b0, tx_busy, tx_full, tx_empty}.
- RX_status_register  out  8  {3'b0, rx_busy, framing_err, overrun, rx_full, rx_empty}.

Behaviour:

Reset values:
- FIFOs empty; bus_data_out = 0.
- serial_data_out = 1.
- TX_status = 8'h01; RX_status = 8'h01.
- All counters and FSMs return to IDLE.
- Reset mid-frame aborts the frame immediately; serial_data_out is 1 on the cycle after reset is sampled.

Baud generator:
- Free-running counter 0..BAUD_DVSR-1.
- Emits a one-cycle tick when the count equals BAUD_DVSR-1, then wraps to 0.

TX FIFO:
- write_data with tx_full=0 stores bus_data_in.
- write_data with tx_full=1 is ignored: data is dropped, no error flag.
- Flags are registered and update the cycle after a push or pop.

TX FSM (IDLE, START, DATA, STOP):
- IDLE: line high. When the FIFO is not empty, pop the head into the shift register and go to START. tx_busy=1 from START through the end of STOP.
- Each bit lasts exactly SAMPLE ticks.
- START drives 0.
- DATA drives DATA_SIZE bits, LSB first.
- STOP drives 1 for one bit, then returns to IDLE. Back-to-back frames follow with no extra idle.

RX path:
- serial_data_in passes through a 2-flop synchronizer.
- IDLE: a falling edge (1 to 0) goes to START.
- START: after SAMPLE/2 ticks, re-sample.
  - If high, treat as a glitch and return to IDLE.
  - If low, reset the tick counter and go to DATA.
- DATA: sample at every SAMPLE-th tick (mid-bit), shift in LSB first, DATA_SIZE bits, then go to STOP.
- STOP: sample after SAMPLE ticks.
  - If 1 and RX FIFO not full: push the byte.
  - If 1 and RX FIFO full: drop the byte, set overrun.
  - If 0: discard the byte, set framing_err.
  - In all cases return to IDLE.
- rx_busy=1 in START, DATA and STOP.

RX FIFO:
- bus_data_out always shows the head entry while not empty.
- read_data with rx_empty=0 advances to the next entry.
- read_data with rx_empty=1 is ignored.
- A push and a pop in the same cycle both take effect; count is unchanged.
- bus_data_out holds its last value when the FIFO becomes empty.

Error flags:
- overrun and framing_err are sticky.
- Both clear on any cycle with read_data=1, or on reset.

FIFO pointers:
- log2(SIZE_FIFO) bits, plus a wrap bit for full/empty discrimination.
- Full after SIZE_FIFO pushes without pops.

Test Plan:
1. Reset, then idle 100 cycles -> serial_data_out=1, TX_status=8'h01, RX_status=8'h01, bus_data_out=0.
2. Set BAUD_DVSR=4 via SYS_FREQ=6400, BAUD_RATE=100. Write 8'hA5 -> serial_data_out is low for 64 cycles, then bits 1,0,1,0,0,1,0,1 at 64 cycles each, then high for 64 cycles. tx_busy=1 throughout the frame.
3. Loop back two instances, A.TX to B.RX. Write 8'h24, 8'h81, 8'h09 back-to-back into A -> after 3 frames plus margin, B shows rx_empty=0. Three read_data pulses return 24, 81, 09, then rx_empty=1.
4. Write 9 bytes while the transmitter is held idle (serial out) -> tx_full=1 after 8 writes; the 9th byte never appears on the line.
5. Drive a frame with stop bit 0 into RX -> framing_err=1, rx_empty stays 1. A read_data pulse clears framing_err.
6. Send 9 frames into RX with no reads -> 8 bytes stored, overrun=1, head equals the first byte. Also drive a 1-tick low glitch on an idle line -> no byte received, rx_busy back to 0 within SAMPLE/2+1 ticks.

Source files
------------

// File: rtl/uart_protocol_core.sv
// uart_protocol_core
//   Full-duplex 8N1 UART endpoint. The bus side has a TX FIFO and a
//   first-word-fall-through RX FIFO. The serial side has a transmitter and a
//   receiver, both paced by one shared 16x-oversampling baud tick.
// Ports:
//   clk                - system clock, rising edge
//   reset              - synchronous active-high reset
//   write_data         - push bus_data_in into the TX FIFO (ignored when full)
//   read_data          - pop the RX FIFO head (ignored when empty); clears errors
//   bus_data_in        - byte to transmit
//   bus_data_out       - RX FIFO head; holds its last value once drained
//   serial_data_in     - asynchronous serial RX line
//   serial_data_out    - serial TX line, idle high
//   TX_status_register - {5'b0, tx_busy, tx_full, tx_empty}
//   RX_status_register - {3'b0, rx_busy, framing_err, overrun, rx_full, rx_empty}
module uart_protocol_core #(
  parameter int DATA_SIZE = 8,
  parameter int SIZE_FIFO = 8,
  parameter int SYS_FREQ  = 100000000,
  parameter int BAUD_RATE = 9600,
  parameter int SAMPLE    = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 write_data,
  input  logic                 read_data,
  input  logic [DATA_SIZE-1:0] bus_data_in,
  output logic [DATA_SIZE-1:0] bus_data_out,
  input  logic                 serial_data_in,
  output logic                 serial_data_out,
  output logic [7:0]           TX_status_register,
  output logic [7:0]           RX_status_register
);
  localparam int BAUD_DVSR = SYS_FREQ / (SAMPLE * BAUD_RATE);
  localparam int BW = (BAUD_DVSR > 1) ? $clog2(BAUD_DVSR) : 1;
  localparam int AW = $clog2(SIZE_FIFO);
  localparam int SW = $clog2(SAMPLE);
  localparam int IW = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1;

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_START = 2'd1, ST_DATA = 2'd2, ST_STOP = 2'd3} state_e;

  logic [BW-1:0]        baud_cnt_q, baud_cnt_d;
  logic                 tick;
  // TX side
  logic [DATA_SIZE-1:0] tx_mem_q [SIZE_FIFO];
  logic [AW:0]          tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
  logic                 tx_full_q, tx_full_d, tx_empty_q, tx_empty_d;
  logic                 tx_push, tx_pop, tx_bit_end;
  state_e               tx_state_q, tx_state_d;
  logic [SW-1:0]        tx_tick_q, tx_tick_d;
  logic [IW-1:0]        tx_bit_q, tx_bit_d;
  logic [DATA_SIZE-1:0] tx_shift_q, tx_shift_d;
  logic                 tx_out_q, tx_out_d, tx_busy_q, tx_busy_d;
  // RX side
  logic                 rx_sync1_q, rx_sync2_q, rx_prev_q;
  logic [DATA_SIZE-1:0] rx_mem_q [SIZE_FIFO];
  logic [AW:0]          rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
  logic                 rx_full_q, rx_full_d, rx_empty_q, rx_empty_d;
  logic                 rx_push, rx_pop, rx_bit_end, rx_half_end;
  state_e               rx_state_q, rx_state_d;
  logic [SW-1:0]        rx_tick_q, rx_tick_d;
  logic [IW-1:0]        rx_bit_q, rx_bit_d;
  logic [DATA_SIZE-1:0] rx_shift_q, rx_shift_d, rx_head_q, rx_head_d;
  logic                 framing_q, framing_d, overrun_q, overrun_d, rx_busy_q, rx_busy_d;

  // Baud generator: one-cycle tick every BAUD_DVSR clocks
  always_comb begin
    tick = (baud_cnt_q == BW'(BAUD_DVSR - 1));
    if (tick) baud_cnt_d = '0;
    else      baud_cnt_d = baud_cnt_q + BW'(1);
  end

  // TX FIFO pointers and registered full/empty flags
  always_comb begin
    tx_push    = write_data & ~tx_full_q;
    tx_wr_d    = tx_wr_q + {{AW{1'b0}}, tx_push};
    tx_rd_d    = tx_rd_q + {{AW{1'b0}}, tx_pop};
    tx_empty_d = (tx_wr_d == tx_rd_d);
    tx_full_d  = (tx_wr_d[AW] != tx_rd_d[AW]) && (tx_wr_d[AW-1:0] == tx_rd_d[AW-1:0]);
  end

  // TX FSM: next state, pop request and next line level
  always_comb begin
    tx_state_d = tx_state_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_pop     = 1'b0;
    tx_bit_end = tick && (tx_tick_q == SW'(SAMPLE - 1));
    if (tick && (tx_state_q != ST_IDLE)) begin
      if (tx_bit_end) tx_tick_d = '0;
      else            tx_tick_d = tx_tick_q + SW'(1);
    end else begin
      tx_tick_d = tx_tick_q;
    end
    case (tx_state_q)
      ST_IDLE: begin
        // Launch on a tick so the start bit spans exactly SAMPLE ticks
        if (tick && !tx_empty_q) begin
          tx_pop     = 1'b1;
          tx_shift_d = tx_mem_q[tx_rd_q[AW-1:0]];
          tx_tick_d  = '0;
          tx_state_d = ST_START;
        end else begin
          tx_state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (tx_bit_end) begin
          tx_bit_d   = '0;
          tx_state_d = ST_DATA;
        end else begin
          tx_state_d = ST_START;
        end
      end
      ST_DATA: begin
        if (tx_bit_end) begin
          tx_shift_d = {1'b0, tx_shift_q[DATA_SIZE-1:1]};
          if (tx_bit_q == IW'(DATA_SIZE - 1)) tx_state_d = ST_STOP;
          else                                tx_bit_d   = tx_bit_q + IW'(1);
        end else begin
          tx_state_d = ST_DATA;
        end
      end
      ST_STOP: begin
        // Chain straight into the next frame when more data is queued
        if (tx_bit_end && !tx_empty_q) begin
          tx_pop     = 1'b1;
          tx_shift_d = tx_mem_q[tx_rd_q[AW-1:0]];
          tx_state_d = ST_START;
        end else if (tx_bit_end) begin
          tx_state_d = ST_IDLE;
        end else begin
          tx_state_d = ST_STOP;
        end
      end
      default: tx_state_d = ST_IDLE;
    endcase
    tx_busy_d = (tx_state_d != ST_IDLE);
    case (tx_state_d)
      ST_START: tx_out_d = 1'b0;
      ST_DATA:  tx_out_d = tx_shift_d[0];
      default:  tx_out_d = 1'b1;
    endcase
  end

  // RX FSM: start detect, mid-bit sampling, stop-bit checks and error flags
  always_comb begin
    rx_state_d  = rx_state_q;
    rx_bit_d    = rx_bit_q;
    rx_shift_d  = rx_shift_q;
    rx_push     = 1'b0;
    framing_d   = framing_q & ~read_data;
    overrun_d   = overrun_q & ~read_data;
    rx_bit_end  = tick && (rx_tick_q == SW'(SAMPLE - 1));
    rx_half_end = tick && (rx_tick_q == SW'(SAMPLE / 2 - 1));
    if (tick && (rx_state_q != ST_IDLE)) begin
      if (rx_bit_end) rx_tick_d = '0;
      else            rx_tick_d = rx_tick_q + SW'(1);
    end else begin
      rx_tick_d = rx_tick_q;
    end
    case (rx_state_q)
      ST_IDLE: begin
        if (rx_prev_q && !rx_sync2_q) begin
          rx_tick_d  = '0;
          rx_state_d = ST_START;
        end else begin
          rx_state_d = ST_IDLE;
        end
      end
      ST_START: begin
        // Half a bit in: a high line means the edge was a glitch
        if (rx_half_end && rx_sync2_q) begin
          rx_tick_d  = '0;
          rx_state_d = ST_IDLE;
        end else if (rx_half_end) begin
          rx_tick_d  = '0;
          rx_bit_d   = '0;
          rx_state_d = ST_DATA;
        end else begin
          rx_state_d = ST_START;
        end
      end
      ST_DATA: begin
        if (rx_bit_end) begin
          rx_shift_d = {rx_sync2_q, rx_shift_q[DATA_SIZE-1:1]};
          if (rx_bit_q == IW'(DATA_SIZE - 1)) rx_state_d = ST_STOP;
          else                                rx_bit_d   = rx_bit_q + IW'(1);
        end else begin
          rx_state_d = ST_DATA;
        end
      end
      ST_STOP: begin
        if (rx_bit_end) begin
          rx_state_d = ST_IDLE;
          if (!rx_sync2_q)    framing_d = 1'b1;
          else if (rx_full_q) overrun_d = 1'b1;
          else                rx_push   = 1'b1;
        end else begin
          rx_state_d = ST_STOP;
        end
      end
      default: rx_state_d = ST_IDLE;
    endcase
    rx_busy_d = (rx_state_d != ST_IDLE);
  end

  // RX FIFO pointers, flags and the registered head word
  always_comb begin
    rx_pop     = read_data & ~rx_empty_q;
    rx_wr_d    = rx_wr_q + {{AW{1'b0}}, rx_push};
    rx_rd_d    = rx_rd_q + {{AW{1'b0}}, rx_pop};
    rx_empty_d = (rx_wr_d == rx_rd_d);
    rx_full_d  = (rx_wr_d[AW] != rx_rd_d[AW]) && (rx_wr_d[AW-1:0] == rx_rd_d[AW-1:0]);
    // The new head is the byte being written now when it lands in the head slot
    if (rx_empty_d) rx_head_d = rx_head_q;
    else if (rx_push && (rx_rd_d[AW-1:0] == rx_wr_q[AW-1:0])) rx_head_d = rx_shift_q;
    else rx_head_d = rx_mem_q[rx_rd_d[AW-1:0]];
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      baud_cnt_q <= '0;
      tx_wr_q <= '0;  tx_rd_q <= '0;  tx_full_q <= 1'b0;  tx_empty_q <= 1'b1;
      tx_state_q <= ST_IDLE;  tx_tick_q <= '0;  tx_bit_q <= '0;  tx_shift_q <= '0;
      tx_out_q <= 1'b1;  tx_busy_q <= 1'b0;
      rx_sync1_q <= 1'b1;  rx_sync2_q <= 1'b1;  rx_prev_q <= 1'b1;
      rx_wr_q <= '0;  rx_rd_q <= '0;  rx_full_q <= 1'b0;  rx_empty_q <= 1'b1;
      rx_state_q <= ST_IDLE;  rx_tick_q <= '0;  rx_bit_q <= '0;  rx_shift_q <= '0;
      rx_head_q <= '0;  framing_q <= 1'b0;  overrun_q <= 1'b0;  rx_busy_q <= 1'b0;
    end else begin
      baud_cnt_q <= baud_cnt_d;
      tx_wr_q <= tx_wr_d;  tx_rd_q <= tx_rd_d;  tx_full_q <= tx_full_d;  tx_empty_q <= tx_empty_d;
      tx_state_q <= tx_state_d;  tx_tick_q <= tx_tick_d;  tx_bit_q <= tx_bit_d;  tx_shift_q <= tx_shift_d;
      tx_out_q <= tx_out_d;  tx_busy_q <= tx_busy_d;
      rx_sync1_q <= serial_data_in;  rx_sync2_q <= rx_sync1_q;  rx_prev_q <= rx_sync2_q;
      rx_wr_q <= rx_wr_d;  rx_rd_q <= rx_rd_d;  rx_full_q <= rx_full_d;  rx_empty_q <= rx_empty_d;
      rx_state_q <= rx_state_d;  rx_tick_q <= rx_tick_d;  rx_bit_q <= rx_bit_d;  rx_shift_q <= rx_shift_d;
      rx_head_q <= rx_head_d;  framing_q <= framing_d;  overrun_q <= overrun_d;  rx_busy_q <= rx_busy_d;
    end
  end

  // FIFO storage; contents are only observed through the reset pointers
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem_q[tx_wr_q[AW-1:0]] <= bus_data_in;
    if (rx_push) rx_mem_q[rx_wr_q[AW-1:0]] <= rx_shift_q;
  end

  assign serial_data_out    = tx_out_q;
  assign bus_data_out       = rx_head_q;
  assign TX_status_register = {5'b00000, tx_busy_q, tx_full_q, tx_empty_q};
  assign RX_status_register = {3'b000, rx_busy_q, framing_q, overrun_q, rx_full_q, rx_empty_q};

endmodule

// File: tb/tb_uart_protocol_core.sv
// tb_uart_protocol_core
//   Directed bench. u_a/u_b run at BAUD_DVSR=4 (64 clocks per bit); u_b's RX
//   is fed either by u_a's TX line or by a bench-driven line. u_c runs at
//   BAUD_DVSR=16 (256 clocks per bit) with its own reset for the TX-full case.
`timescale 1ns/1ps
module tb_uart_protocol_core;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, c_reset;
  logic       a_wr, a_rd, b_wr, b_rd, c_wr, c_rd, one_line;
  logic [7:0] a_din, b_din, c_din, a_dout, b_dout, c_dout;
  logic [7:0] a_txs, a_rxs, b_txs, b_rxs, c_txs, c_rxs;
  logic       a_tx, b_tx, c_tx, loop_sel, tb_rx, b_rx_in;

  assign b_rx_in = loop_sel ? a_tx : tb_rx;

  uart_protocol_core #(.SYS_FREQ(6400), .BAUD_RATE(100)) u_a (
    .clk(clk), .reset(reset), .write_data(a_wr), .read_data(a_rd),
    .bus_data_in(a_din), .bus_data_out(a_dout), .serial_data_in(one_line),
    .serial_data_out(a_tx), .TX_status_register(a_txs), .RX_status_register(a_rxs));

  uart_protocol_core #(.SYS_FREQ(6400), .BAUD_RATE(100)) u_b (
    .clk(clk), .reset(reset), .write_data(b_wr), .read_data(b_rd),
    .bus_data_in(b_din), .bus_data_out(b_dout), .serial_data_in(b_rx_in),
    .serial_data_out(b_tx), .TX_status_register(b_txs), .RX_status_register(b_rxs));

  uart_protocol_core #(.SYS_FREQ(25600), .BAUD_RATE(100)) u_c (
    .clk(clk), .reset(c_reset), .write_data(c_wr), .read_data(c_rd),
    .bus_data_in(c_din), .bus_data_out(c_dout), .serial_data_in(one_line),
    .serial_data_out(c_tx), .TX_status_register(c_txs), .RX_status_register(c_rxs));

  int err_cnt = 0;
  int chk_cnt = 0;

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One bit on the bench-driven RX line of u_b (64 clocks)
  task automatic drive_bit(input logic v);
    tb_rx = v;
    repeat (64) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(stop_bit);
    drive_bit(1'b1);
  endtask

  task automatic read_b();
    @(negedge clk);
    b_rd = 1'b1;
    @(negedge clk);
    b_rd = 1'b0;
  endtask

  // Decode one frame from u_c's line: 256 clocks per bit, sampled mid-bit
  task automatic decode_c(output logic [7:0] d, output logic start_ok, output logic stop_ok,
                          output logic seen);
    seen = 1'b0; d = 8'h00; start_ok = 1'b0; stop_ok = 1'b0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge clk);
      if (c_tx == 1'b0) seen = 1'b1;
    end
    if (seen) begin
      repeat (128) @(negedge clk);
      start_ok = ~c_tx;
      for (int k = 0; k < 8; k++) begin
        repeat (256) @(negedge clk);
        d[k] = c_tx;
      end
      repeat (256) @(negedge clk);
      stop_ok = c_tx;
    end
  endtask

  // Absolute time limit
  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] d;
    logic       s_ok, p_ok, seen, found, done, saw_low;
    logic [7:0] exp_a5;
    int         busy_cycles;

    reset = 1'b1; c_reset = 1'b1; one_line = 1'b1;
    a_wr = 1'b0; a_rd = 1'b0; b_wr = 1'b0; b_rd = 1'b0; c_wr = 1'b0; c_rd = 1'b0;
    a_din = 8'h00; b_din = 8'h00; c_din = 8'h00; loop_sel = 1'b0; tb_rx = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    repeat (100) @(negedge clk);

    // Reset / idle state
    check_val("rst_a_tx", a_tx, 1'b1);
    check_val("rst_a_txs", a_txs, 8'h01);
    check_val("rst_a_rxs", a_rxs, 8'h01);
    check_val("rst_b_rxs", b_rxs, 8'h01);
    check_val("rst_b_dout", b_dout, 8'h00);
    check_val("rst_c_tx", c_tx, 1'b1);

    // Single frame 8'hA5 on u_a: 64 clocks per bit
    exp_a5 = 8'hA5;
    @(negedge clk); a_wr = 1'b1; a_din = exp_a5;
    @(negedge clk); a_wr = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (a_tx == 1'b0) found = 1'b1;
      else @(negedge clk);
    end
    check_val("tx_start_seen", found, 1'b1);
    repeat (63) @(negedge clk);
    check_val("tx_start_len63", a_tx, 1'b0);
    check_val("tx_busy_start", a_txs[2], 1'b1);
    @(negedge clk);
    check_val("tx_start_end64", a_tx, 1'b1);
    repeat (32) @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      check_val($sformatf("tx_bit%0d", k), a_tx, exp_a5[k]);
      check_val($sformatf("tx_busy_bit%0d", k), a_txs[2], 1'b1);
      repeat (64) @(negedge clk);
    end
    check_val("tx_stop", a_tx, 1'b1);
    check_val("tx_busy_stop", a_txs[2], 1'b1);
    repeat (64) @(negedge clk);
    check_val("tx_idle_after", a_tx, 1'b1);
    check_val("tx_status_after", a_txs, 8'h01);

    // Loopback u_a -> u_b, three back-to-back bytes
    loop_sel = 1'b1;
    repeat (10) @(negedge clk);
    @(negedge clk); a_wr = 1'b1; a_din = 8'h24;
    @(negedge clk); a_din = 8'h81;
    @(negedge clk); a_din = 8'h09;
    @(negedge clk); a_wr = 1'b0;
    repeat (2100) @(negedge clk);
    check_val("lb_status", b_rxs, 8'h00);
    check_val("lb_byte0", b_dout, 8'h24);
    read_b();
    check_val("lb_byte1", b_dout, 8'h81);
    read_b();
    check_val("lb_byte2", b_dout, 8'h09);
    read_b();
    check_val("lb_empty", b_rxs, 8'h01);
    check_val("lb_hold", b_dout, 8'h09);
    loop_sel = 1'b0;
    repeat (10) @(negedge clk);

    // Framing error: stop bit 0
    send_frame(8'h3C, 1'b0);
    check_val("fe_status", b_rxs, 8'h09);
    read_b();
    check_val("fe_cleared", b_rxs, 8'h01);

    // Overrun: 9 frames, no reads
    for (int i = 0; i < 9; i++) send_frame(8'h50 + 8'(i), 1'b1);
    check_val("ov_status", b_rxs, 8'h06);
    check_val("ov_head", b_dout, 8'h50);
    for (int i = 0; i < 8; i++) begin
      check_val($sformatf("ov_byte%0d", i), b_dout, 8'h50 + 8'(i));
      read_b();
      if (i == 0) check_val("ov_cleared", b_rxs, 8'h00);
    end
    check_val("ov_drained", b_rxs, 8'h01);
    check_val("ov_hold", b_dout, 8'h57);

    // Short low glitch on an idle line
    @(negedge clk); tb_rx = 1'b0;
    repeat (4) @(negedge clk);
    tb_rx = 1'b1;
    seen = 1'b0; done = 1'b0; busy_cycles = 0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (b_rxs[4]) begin
        seen = 1'b1;
        busy_cycles++;
      end else if (seen) begin
        done = 1'b1;
      end
    end
    check_val("glitch_busy_seen", seen, 1'b1);
    check_val("glitch_busy_done", done, 1'b1);
    check_val("glitch_busy_len", (busy_cycles <= 36), 1'b1);
    repeat (10) @(negedge clk);
    check_val("glitch_status", b_rxs, 8'h01);

    // TX FIFO full on u_c: nine writes before the first baud tick
    @(negedge clk); c_reset = 1'b0; c_wr = 1'b1; c_din = 8'hC0;
    for (int i = 1; i < 9; i++) begin
      @(negedge clk);
      if (i == 7) check_val("full_after7", c_txs, 8'h00);
      if (i == 8) check_val("full_after8", c_txs, 8'h02);
      c_din = 8'hC0 + 8'(i);
    end
    @(negedge clk); c_wr = 1'b0;
    check_val("full_after9", c_txs, 8'h02);
    for (int k = 0; k < 8; k++) begin
      decode_c(d, s_ok, p_ok, seen);
      check_val($sformatf("c_frame%0d_seen", k), seen, 1'b1);
      check_val($sformatf("c_frame%0d_data", k), d, 8'hC0 + 8'(k));
      check_val($sformatf("c_frame%0d_framing", k), {s_ok, p_ok}, 2'b11);
    end
    saw_low = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (c_tx == 1'b0) saw_low = 1'b1;
    end
    check_val("ninth_not_sent", saw_low, 1'b0);
    check_val("c_tx_status_end", c_txs, 8'h01);

    // Reset mid-frame forces the line high on the next cycle
    @(negedge clk); c_wr = 1'b1; c_din = 8'h00;
    @(negedge clk); c_wr = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (c_tx == 1'b0) found = 1'b1;
    end
    check_val("midrst_frame_started", found, 1'b1);
    repeat (300) @(negedge clk);
    c_reset = 1'b1;
    @(negedge clk);
    check_val("midrst_line", c_tx, 1'b1);
    check_val("midrst_status", c_txs, 8'h01);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end
endmodule
